// File: rtl/tag_recv_pkg.sv
// Shared types and helpers for the tag receive block.
// Slot states and the column range helper live here.
package tag_pkg;

    localparam int NUM_COL = 8;
    localparam int TAG_W   = $clog2(NUM_COL) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DIS
    } slot_st_t;

    // Column j belongs to the active kernel when j < kernel_size.
    function automatic logic range_bit(
        input int         j,
        input logic [7:0] ks
    );
        return j < int'(ks);
    endfunction

    function automatic logic [NUM_COL-1:0] range_mask(
        input logic [7:0] ks
    );
        logic [NUM_COL-1:0] m;
        for (int j = 0; j < NUM_COL; j++) begin
            m[j] = range_bit(j, ks);
        end
        return m;
    endfunction

endpackage

// File: rtl/tag_recv_if.sv
// Allocator/PE column bundle for the tag receiver.
// master = allocator + PE array side, slave = tag_recv.
interface tag_recv_if #(
    parameter int NUM_COL = 8,
    parameter int TAG_W   = $clog2(NUM_COL) + 1
);

    logic [NUM_COL-1:0][TAG_W-1:0] tag_in;
    logic [NUM_COL-1:0]            col_done;
    logic [NUM_COL-1:0]            tag_locks;
    logic [NUM_COL-1:0][TAG_W-1:0] col_tag;
    logic [NUM_COL-1:0]            col_start;

    modport master (
        output tag_in,
        output col_done,
        input  tag_locks,
        input  col_tag,
        input  col_start
    );

    modport slave (
        input  tag_in,
        input  col_done,
        output tag_locks,
        output col_tag,
        output col_start
    );

endinterface

// File: rtl/tag_recv_slot.sv
// One receive slot: IDLE/RUN/DIS state, captured tag and start pulse.
// Completion and protocol events go up to the top for counting.
module tag_recv_slot
    import tag_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_range,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             col_done,
    output logic             lock,
    output logic [TAG_W-1:0] col_tag,
    output logic             col_start,
    output logic             done_evt,
    output logic             err
);

    slot_st_t st;
    logic     has_tag;

    assign has_tag  = |tag_in;
    assign done_evt = !flush && (st == RUN) && col_done;

    // Illegal events are flagged but never change the slot.
    assign err = !flush &&
                 ((has_tag && (st != IDLE)) ||
                  (col_done && (st != RUN)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            lock      <= 1'b0;
            col_tag   <= '0;
            col_start <= 1'b0;
        end else begin
            col_start <= 1'b0;
            if (flush) begin
                st      <= in_range ? IDLE : DIS;
                lock    <= !in_range;
                col_tag <= '0;
            end else begin
                unique case (st)
                    IDLE: begin
                        if (!in_range) begin
                            st   <= DIS;
                            lock <= 1'b1;
                        end else if (has_tag) begin
                            st        <= RUN;
                            lock      <= 1'b1;
                            col_tag   <= tag_in;
                            col_start <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (col_done) begin
                            st      <= in_range ? IDLE : DIS;
                            lock    <= !in_range;
                            col_tag <= '0;
                        end
                    end
                    DIS: begin
                        if (in_range) begin
                            st   <= IDLE;
                            lock <= 1'b0;
                        end
                    end
                    default: begin
                        st      <= IDLE;
                        lock    <= 1'b0;
                        col_tag <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/tag_recv.sv
// Column-side tag responder: per-column slots plus completion
// counting, all-done tracking and a sticky protocol error flag.
module tag_recv
    import tag_pkg::*;
#(
    parameter int NUM_COL = 8,
    parameter int TAG_W   = $clog2(NUM_COL) + 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [7:0]       kernel_size,
    tag_recv_if.slave        col,
    output logic [CNT_W-1:0] done_cnt,
    output logic             all_done,
    output logic             proto_err
);

    logic [NUM_COL-1:0]            in_range;
    logic [NUM_COL-1:0]            lock;
    logic [NUM_COL-1:0][TAG_W-1:0] tag_q;
    logic [NUM_COL-1:0]            start;
    logic [NUM_COL-1:0]            done_evt;
    logic [NUM_COL-1:0]            err;
    logic [NUM_COL-1:0]            done_mask;
    logic [CNT_W-1:0]              cnt_inc;
    logic                          mask_full;

    always_comb begin
        in_range = '0;
        for (int j = 0; j < NUM_COL; j++) begin
            in_range[j] = range_bit(j, kernel_size);
        end
    end

    for (genvar j = 0; j < NUM_COL; j++) begin : g_slot
        tag_recv_slot #(
            .TAG_W (TAG_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_range  (in_range[j]),
            .tag_in    (col.tag_in[j]),
            .col_done  (col.col_done[j]),
            .lock      (lock[j]),
            .col_tag   (tag_q[j]),
            .col_start (start[j]),
            .done_evt  (done_evt[j]),
            .err       (err[j])
        );
    end

    assign col.tag_locks = lock;
    assign col.col_tag   = tag_q;
    assign col.col_start = start;

    // Several columns may finish in the same cycle.
    always_comb begin
        cnt_inc = '0;
        for (int j = 0; j < NUM_COL; j++) begin
            cnt_inc = cnt_inc + CNT_W'(done_evt[j]);
        end
    end

    // An empty kernel never counts as complete.
    assign mask_full = (|in_range) &&
                       ((done_mask & in_range) == in_range);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt  <= '0;
            done_mask <= '0;
            all_done  <= 1'b0;
            proto_err <= 1'b0;
        end else if (flush) begin
            done_cnt  <= '0;
            done_mask <= '0;
            all_done  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            done_cnt  <= done_cnt + cnt_inc;
            done_mask <= done_mask | done_evt;
            all_done  <= mask_full;
            proto_err <= proto_err | (|err);
        end
    end

endmodule

// File: tb/tb_tag_recv.sv
// Self-checking bench for tag_recv: vector table, corner sequences
// and a random run against a rule-level reference model.
module tb_tag_recv;

    localparam int N  = 8;
    localparam int TW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [7:0]    kernel_size;
    logic [CW-1:0] done_cnt;
    logic          all_done;
    logic          proto_err;

    tag_recv_if #(.NUM_COL(N), .TAG_W(TW)) bus ();

    tag_recv #(
        .NUM_COL (N),
        .TAG_W   (TW),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .kernel_size (kernel_size),
        .col         (bus.slave),
        .done_cnt    (done_cnt),
        .all_done    (all_done),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = free, 1 = busy with a tag, 2 = disabled.
    int m_st   [N];
    int m_tag  [N];
    bit m_start[N];
    bit m_done [N];
    int m_cnt;
    bit m_all;
    bit m_err;

    function automatic void m_reset();
        for (int j = 0; j < N; j++) begin
            m_st[j]    = 0;
            m_tag[j]   = 0;
            m_start[j] = 0;
            m_done[j]  = 0;
        end
        m_cnt = 0;
        m_all = 0;
        m_err = 0;
    endfunction

    function automatic void m_step();
        int ks;
        int nd;
        bit allv;
        int tg;
        bit dn;
        bit inr;
        ks = int'(kernel_size);
        if (rst) begin
            m_reset();
            return;
        end
        if (flush) begin
            for (int j = 0; j < N; j++) begin
                m_st[j]    = (j < ks) ? 0 : 2;
                m_tag[j]   = 0;
                m_start[j] = 0;
                m_done[j]  = 0;
            end
            m_cnt = 0;
            m_all = 0;
            m_err = 0;
            return;
        end
        allv = (ks > 0);
        for (int j = 0; j < N; j++) begin
            if (j < ks && !m_done[j]) allv = 0;
        end
        nd = 0;
        for (int j = 0; j < N; j++) begin
            tg  = int'(bus.tag_in[j]);
            dn  = bus.col_done[j];
            inr = (j < ks);
            m_start[j] = 0;
            if (m_st[j] == 0) begin
                if (dn) m_err = 1;
                if (!inr) m_st[j] = 2;
                else if (tg != 0) begin
                    m_st[j]    = 1;
                    m_tag[j]   = tg;
                    m_start[j] = 1;
                end
            end else if (m_st[j] == 1) begin
                if (tg != 0) m_err = 1;
                if (dn) begin
                    nd++;
                    m_done[j] = 1;
                    m_tag[j]  = 0;
                    m_st[j]   = inr ? 0 : 2;
                end
            end else begin
                if (tg != 0 || dn) m_err = 1;
                if (inr) m_st[j] = 0;
            end
        end
        m_cnt = (m_cnt + nd) % (1 << CW);
        m_all = allv;
    endfunction

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic chk_model(string nm);
        logic [N-1:0]         el;
        logic [N-1:0]         es;
        logic [N-1:0][TW-1:0] et;
        for (int j = 0; j < N; j++) begin
            el[j] = (m_st[j] != 0);
            es[j] = m_start[j];
            et[j] = TW'(m_tag[j]);
        end
        n_tests++;
        if (bus.tag_locks !== el || bus.col_start !== es ||
            bus.col_tag !== et || done_cnt !== CW'(m_cnt) ||
            all_done !== m_all || proto_err !== m_err) begin
            n_fail++;
            $display("FAIL %s @%0t (got/want): lock %b/%b start %b/%b tag %h/%h cnt %0d/%0d all %b/%b err %b/%b",
                     nm, $time, bus.tag_locks, el, bus.col_start, es,
                     bus.col_tag, et, done_cnt, m_cnt, all_done, m_all,
                     proto_err, m_err);
        end
    endtask

    typedef struct {
        bit         fl;
        logic [7:0] ks;
        logic [31:0] tg;
        logic [7:0] dn;
        logic [7:0] e_lock;
        logic [7:0] e_start;
        logic [15:0] e_cnt;
        bit         e_all;
        bit         e_err;
    } vec_t;

    function automatic vec_t mk(
        bit fl, logic [7:0] ks, logic [31:0] tg, logic [7:0] dn,
        logic [7:0] lk, logic [7:0] st, logic [15:0] cnt,
        bit al, bit er
    );
        vec_t v;
        v.fl = fl; v.ks = ks; v.tg = tg; v.dn = dn;
        v.e_lock = lk; v.e_start = st; v.e_cnt = cnt;
        v.e_all = al; v.e_err = er;
        return v;
    endfunction

    function automatic void drive_idle();
        flush        = 1'b0;
        bus.tag_in   = '0;
        bus.col_done = '0;
    endfunction

    vec_t vecs[10];
    int   ks_opts[8] = '{0, 1, 2, 3, 5, 7, 8, 12};

    initial begin
        // Tag nibble j of tg targets column j.
        vecs[0] = mk(0, 3, 32'h0000_0000, 8'h00, 8'hF8, 8'h00, 0, 0, 0);
        vecs[1] = mk(0, 3, 32'h0000_0001, 8'h00, 8'hF9, 8'h01, 0, 0, 0);
        vecs[2] = mk(0, 3, 32'h0000_0000, 8'h00, 8'hF9, 8'h00, 0, 0, 0);
        vecs[3] = mk(0, 3, 32'h0000_0320, 8'h00, 8'hFF, 8'h06, 0, 0, 0);
        vecs[4] = mk(0, 3, 32'h0000_0000, 8'h00, 8'hFF, 8'h00, 0, 0, 0);
        vecs[5] = mk(0, 3, 32'h0000_0000, 8'h07, 8'hF8, 8'h00, 3, 0, 0);
        vecs[6] = mk(0, 3, 32'h0000_0000, 8'h00, 8'hF8, 8'h00, 3, 1, 0);
        vecs[7] = mk(0, 3, 32'h0000_0020, 8'h00, 8'hFA, 8'h02, 3, 1, 0);
        vecs[8] = mk(0, 3, 32'h0000_0020, 8'h00, 8'hFA, 8'h00, 3, 1, 1);
        vecs[9] = mk(1, 3, 32'h0000_0000, 8'h00, 8'hF8, 8'h00, 0, 0, 0);

        rst         = 1'b1;
        kernel_size = 8'd3;
        drive_idle();
        m_reset();
        #12;
        chk("reset_outputs",
            {8'h0, bus.tag_locks, bus.col_start, bus.col_tag,
             done_cnt, 5'h0, all_done, proto_err, 1'b0}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            flush        = vecs[i].fl;
            kernel_size  = vecs[i].ks;
            bus.tag_in   = vecs[i].tg;
            bus.col_done = vecs[i].dn;
            tick();
            chk($sformatf("vec%0d", i),
                {22'h0, bus.tag_locks, bus.col_start, done_cnt,
                 all_done, proto_err},
                {22'h0, vecs[i].e_lock, vecs[i].e_start, vecs[i].e_cnt,
                 vecs[i].e_all, vecs[i].e_err});
            chk_model($sformatf("vec%0d_model", i));
            if (i == 8) chk("run_tag_held", 64'(bus.col_tag[1]), 64'd2);
        end

        // Flush beats a completion and a capture in the same cycle.
        drive_idle();
        bus.tag_in[0] = 4'd1;
        tick();
        chk_model("pre_flush");
        flush           = 1'b1;
        bus.tag_in      = '0;
        bus.tag_in[2]   = 4'd4;
        bus.col_done[0] = 1'b1;
        tick();
        chk("flush_no_start", 64'(bus.col_start), 64'h0);
        chk("flush_cnt", 64'(done_cnt), 64'h0);
        chk("flush_locks", 64'(bus.tag_locks), 64'hF8);
        chk_model("flush_model");

        // Kernel shrinks under a running column.
        drive_idle();
        kernel_size = 8'd8;
        tick();
        chk_model("ks8");
        bus.tag_in[5] = 4'd5;
        tick();
        chk_model("cap5");
        drive_idle();
        kernel_size = 8'd2;
        tick();
        chk("shrink_lock5", 64'(bus.tag_locks[5]), 64'h1);
        chk("shrink_tag5", 64'(bus.col_tag[5]), 64'h5);
        chk_model("shrink_model");
        bus.col_done[5] = 1'b1;
        tick();
        chk("dis_locks", 64'(bus.tag_locks), 64'hFC);
        chk("dis_tag5", 64'(bus.col_tag[5]), 64'h0);
        chk_model("dis_model");

        // Asynchronous reset in the middle of a run.
        drive_idle();
        kernel_size = 8'd3;
        tick();
        bus.tag_in[0] = 4'd1;
        tick();
        chk_model("pre_rst");
        bus.tag_in = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async",
            {8'h0, bus.tag_locks, bus.col_start, bus.col_tag,
             done_cnt, 5'h0, all_done, proto_err, 1'b0}, 64'h0);
        tick();
        chk_model("rst_hold");
        rst = 1'b0;
        bus.tag_in[0] = 4'd1;
        tick();
        chk("post_rst_locks", 64'(bus.tag_locks), 64'hF9);
        chk("post_rst_start", 64'(bus.col_start), 64'h01);
        chk("post_rst_tag", 64'(bus.col_tag[0]), 64'h1);
        chk_model("post_rst_model");

        // Random traffic, mostly legal, with occasional violations.
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) kernel_size = 8'(ks_opts[$urandom_range(0, 7)]);
            flush = ($urandom_range(0, 29) == 0);
            for (int j = 0; j < N; j++) begin
                bus.tag_in[j]   = '0;
                bus.col_done[j] = 1'b0;
                if (m_st[j] == 0 && $urandom_range(0, 2) == 0)
                    bus.tag_in[j] = TW'($urandom_range(1, 15));
                else if ($urandom_range(0, 60) == 0)
                    bus.tag_in[j] = TW'($urandom_range(1, 15));
                if (m_st[j] == 1 && $urandom_range(0, 2) == 0)
                    bus.col_done[j] = 1'b1;
                else if ($urandom_range(0, 80) == 0)
                    bus.col_done[j] = 1'b1;
            end
            tick();
            chk_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
